// File: rtl/stream_demux_1to4.sv
// stream_demux_1to4
//   Registered 1-to-4 stream demultiplexer. One valid/ready input stream is
//   routed to one of four output channels. The route is chosen by in_sel on
//   the first beat of a packet and held until the in_last beat. Each output
//   owns a one-entry register buffer. Beats aimed at a disabled channel are
//   accepted and thrown away, and each dropped packet is counted.
// Ports
//   clk, rst             clock (rising edge), synchronous active-high reset
//   in_valid/in_ready    input handshake (in_ready is combinational)
//   in_data, in_last     input beat payload and end-of-packet flag
//   in_sel               destination channel, sampled on the first beat only
//   out_valid/out_ready  per-channel output handshake
//   out_data             channel k at [k*DATA_W +: DATA_W]
//   out_last             per-channel end-of-packet flag
//   busy                 high while inside a multi-beat packet
//   drop_cnt             saturating count of dropped packets
module stream_demux_1to4 #(
  parameter int         DATA_W = 8,
  parameter logic [3:0] CH_EN  = 4'hF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  input  logic [1:0]          in_sel,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*DATA_W-1:0] out_data,
  output logic [3:0]          out_last,
  output logic                busy,
  output logic [7:0]          drop_cnt
);

  typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] sel_q;
  logic [1:0] tgt;
  logic       tgt_en;
  logic       acc;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Route is locked to sel_q for the remainder of a packet.
  assign tgt    = (state == PASS) ? sel_q : in_sel;
  assign tgt_en = CH_EN[tgt];

  // A disabled target always accepts; an enabled one accepts when its buffer
  // is empty or is being drained on this same edge.
  assign in_ready = !rst && (!tgt_en || !out_valid[tgt] || out_ready[tgt]);
  assign acc      = in_valid && in_ready;
  assign busy     = (state == PASS);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc && !in_last) state_nxt = PASS;
      PASS:    if (acc && in_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: FSM, locked route, drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= 2'd0;
      drop_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && acc && !in_last)
        sel_q <= in_sel;
      if (acc && in_last && !tgt_en)
        drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // Output buffers: load has priority over drain, so a simultaneous
  // drain+load keeps the buffer valid with the new beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 4'b0000;
      out_last  <= 4'b0000;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (acc && tgt_en && (tgt == 2'(k))) begin
          out_valid[k]                  <= 1'b1;
          out_last[k]                   <= in_last;
          out_data[k*DATA_W +: DATA_W]  <= in_data;
        end else if (out_valid[k] && out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_1to4.sv
module tb_stream_demux_1to4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_a, in_valid_m;
  logic        in_ready_a, in_ready_m;
  logic [7:0]  in_data;
  logic        in_last;
  logic [1:0]  in_sel;
  logic [3:0]  out_ready;
  logic [3:0]  out_valid_a, out_valid_m;
  logic [31:0] out_data_a, out_data_m;
  logic [3:0]  out_last_a, out_last_m;
  logic        busy_a, busy_m;
  logic [7:0]  drop_cnt_a, drop_cnt_m;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int first_vld [4];

  logic [8:0] exp_a [4][$];
  logic [8:0] exp_m [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_demux_1to4 #(.DATA_W(8), .CH_EN(4'hF)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .in_sel(in_sel),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_last(out_last_a), .busy(busy_a), .drop_cnt(drop_cnt_a)
  );

  stream_demux_1to4 #(.DATA_W(8), .CH_EN(4'b0111)) u_dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid_m), .in_ready(in_ready_m),
    .in_data(in_data), .in_last(in_last), .in_sel(in_sel),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
    .out_last(out_last_m), .busy(busy_m), .drop_cnt(drop_cnt_m)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: every completed output handshake is matched against the
  // oldest expected beat for that channel.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (out_valid_a[k] && first_vld[k] < 0) first_vld[k] = cyc;
      if (out_valid_a[k] && out_ready[k]) begin
        if (exp_a[k].size() == 0) chk("a_unexpected_beat", 32'(k), 32'hFF);
        else chk("a_beat", {23'd0, out_last_a[k], out_data_a[k*8 +: 8]}, {23'd0, exp_a[k].pop_front()});
      end
      if (out_valid_m[k] && out_ready[k]) begin
        if (exp_m[k].size() == 0) chk("m_unexpected_beat", 32'(k), 32'hFF);
        else chk("m_beat", {23'd0, out_last_m[k], out_data_m[k*8 +: 8]}, {23'd0, exp_m[k].pop_front()});
      end
    end
  end

  // Presents one beat and waits for it to be accepted; ch < 0 means the beat
  // is expected to be dropped. Returns 1 ns after the accepting edge with
  // in_valid still high so successive calls stream back-to-back.
  task automatic send(input bit m, input logic [1:0] sel, input logic [7:0] d,
                      input logic last, input int ch);
    logic rdy;
    in_sel  = sel;
    in_data = d;
    in_last = last;
    if (m) in_valid_m = 1'b1; else in_valid_a = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = m ? in_ready_m : in_ready_a;
      if (rdy) begin
        if (ch >= 0) begin
          if (m) exp_m[ch].push_back({last, d});
          else   exp_a[ch].push_back({last, d});
        end
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid_a = 1'b0;
    in_valid_m = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 4; k++) first_vld[k] = -1;
    rst = 1'b1; in_valid_a = 1'b0; in_valid_m = 1'b0;
    in_data = 8'h00; in_last = 1'b0; in_sel = 2'd0; out_ready = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid_a), 32'h0);
    chk("rst_out_data",  out_data_a, 32'h0);
    chk("rst_out_last",  32'(out_last_a), 32'h0);
    chk("rst_busy",      32'(busy_a), 32'h0);
    chk("rst_drop_cnt",  32'(drop_cnt_a), 32'h0);
    chk("rst_in_ready",  32'(in_ready_a), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: single beat to ch2
    send(0, 2'd2, 8'hA5, 1'b1, 2);
    idle();
    @(negedge clk);
    chk("t1_out_valid", 32'(out_valid_a), 32'h4);
    chk("t1_data",      32'(out_data_a[23:16]), 32'hA5);
    chk("t1_last",      32'(out_last_a[2]), 32'h1);
    chk("t1_busy",      32'(busy_a), 32'h0);
    @(negedge clk);
    chk("t1_out_valid_clr", 32'(out_valid_a), 32'h0);
    @(posedge clk); #1;

    // 2: 4-beat packet locked to ch1 while in_sel wanders
    send(0, 2'd1, 8'h01, 1'b0, 1); chk("t2_busy0", 32'(busy_a), 32'h1);
    send(0, 2'd0, 8'h02, 1'b0, 1); chk("t2_busy1", 32'(busy_a), 32'h1);
    send(0, 2'd3, 8'h03, 1'b0, 1); chk("t2_busy2", 32'(busy_a), 32'h1);
    send(0, 2'd2, 8'h04, 1'b1, 1); chk("t2_busy3", 32'(busy_a), 32'h0);
    idle();
    repeat (3) @(posedge clk); #1;

    // 3: backpressure on ch0
    out_ready = 4'b1110;
    fork
      begin
        send(0, 2'd0, 8'h31, 1'b0, 0);
        send(0, 2'd0, 8'h32, 1'b0, 0);
        send(0, 2'd0, 8'h33, 1'b1, 0);
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        chk("t3_stall_in_ready", 32'(in_ready_a), 32'h0);
        chk("t3_buf_full",       32'(out_valid_a[0]), 32'h1);
        chk("t3_buf_data",       32'(out_data_a[7:0]), 32'h31);
        @(posedge clk); #1 out_ready = 4'hF;
      end
    join
    repeat (3) @(posedge clk); #1;
    chk("t3_drained", 32'(exp_a[0].size()), 32'h0);

    // 4: ch3 disabled on the masked instance
    for (int p = 0; p < 3; p++) begin
      send(1, 2'd3, 8'(8'h70 + p), 1'b0, -1);
      send(1, 2'd3, 8'(8'h78 + p), 1'b1, -1);
    end
    send(1, 2'd0, 8'h40, 1'b1, 0);
    idle();
    @(negedge clk);
    chk("t4_drop3", 32'(drop_cnt_m), 32'd3);
    chk("t4_ch3_quiet", 32'(out_valid_m[3]), 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 252; i++) send(1, 2'd3, 8'(i), 1'b1, -1);
    idle();
    @(negedge clk);
    chk("t4_drop255", 32'(drop_cnt_m), 32'd255);
    @(posedge clk); #1;
    for (int i = 0; i < 48; i++) send(1, 2'd3, 8'(i), 1'b1, -1);
    idle();
    @(negedge clk);
    chk("t4_drop_sat", 32'(drop_cnt_m), 32'd255);
    @(posedge clk); #1;

    // 5: back-to-back packets to different channels
    for (int k = 0; k < 4; k++) first_vld[k] = -1;
    begin
      int t0;
      t0 = cyc;
      send(0, 2'd0, 8'h51, 1'b1, 0);
      send(0, 2'd3, 8'h52, 1'b0, 3);
      send(0, 2'd3, 8'h53, 1'b1, 3);
      chk("t5_accept_cycles", 32'(cyc - t0), 32'd3);
    end
    idle();
    repeat (3) @(posedge clk); #1;
    chk("t5_ch3_after_ch0", 32'(first_vld[3] - first_vld[0]), 32'd1);

    // 6: reset in the middle of a ch2 packet
    send(0, 2'd2, 8'h61, 1'b0, 2);
    send(0, 2'd2, 8'h62, 1'b0, 2);
    chk("t6_busy_pre", 32'(busy_a), 32'h1);
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_in_ready_rst", 32'(in_ready_a), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", 32'(out_valid_a), 32'h0);
    chk("t6_busy",      32'(busy_a), 32'h0);
    chk("t6_drop_cnt",  32'(drop_cnt_a), 32'h0);
    @(posedge clk); #1;
    send(0, 2'd1, 8'h64, 1'b1, 1);
    idle();
    @(negedge clk);
    chk("t6_route_ch1", 32'(out_valid_a), 32'h2);
    repeat (3) @(posedge clk); #1;

    for (int k = 0; k < 4; k++) begin
      chk("sb_empty_a", 32'(exp_a[k].size()), 32'h0);
      chk("sb_empty_m", 32'(exp_m[k].size()), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
